// File: rtl/memory_arbiter_if.sv
//-----------------------------------------------------------------------------
// memory_arbiter_if
//
// Bundles the requester-side handshake and the single-port memory bus that
// memory_arbiter sits between.
//
//   req    [NREQ]          per-requester access request
//   we     [NREQ]          per-requester 1=write / 0=read
//   addr   [NREQ*AWIDTH]   packed addresses, requester i at [i*AWIDTH +: AWIDTH]
//   wdata  [NREQ*DWIDTH]   packed write data, requester i at [i*DWIDTH +: DWIDTH]
//   gnt    [NREQ]          one-cycle grant pulse
//   rvalid [NREQ]          one-cycle read-data-valid pulse
//   rdata  [DWIDTH]        shared read data
//   busy                   arbiter has a transaction in flight
//   mem_read / mem_write   memory strobes
//   mem_addr / mem_wdata   memory address / write data
//   mem_rdata              memory read data (one clock after mem_read)
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus memory)
//-----------------------------------------------------------------------------
interface memory_arbiter_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5,
  parameter int NREQ   = 2
);

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*AWIDTH-1:0] addr;
  logic [NREQ*DWIDTH-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DWIDTH-1:0]      rdata;
  logic                   busy;
  logic                   mem_read;
  logic                   mem_write;
  logic [AWIDTH-1:0]      mem_addr;
  logic [DWIDTH-1:0]      mem_wdata;
  logic [DWIDTH-1:0]      mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/memory_arbiter.sv
//-----------------------------------------------------------------------------
// memory_arbiter
//
// Round-robin arbiter/sequencer sharing one single-port memory between NREQ
// requesters. One single-beat read or write is serialised per grant; read
// data comes back on the shared rdata bus with a per-requester rvalid pulse.
//
// Ports:
//   clk    - system clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - memory_arbiter_if.slave: requester handshake and memory bus
//
// Sequence (T = IDLE cycle in which req is sampled):
//   T+1  GRANT : gnt[idx] and one memory strobe
//   T+2  RWAIT : reads only, memory returns data at end of cycle
//   T+3  rvalid[idx] / rdata (reads)
// The first IDLE cycle after a transaction masks the requester just served,
// so a request still held from the previous access is not served twice.
//
// The widths of the interface instance must match DWIDTH/AWIDTH/NREQ here.
//-----------------------------------------------------------------------------
module memory_arbiter #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5,
  parameter int NREQ   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  memory_arbiter_if.slave   bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RWAIT = 2'd2
  } state_t;

  state_t            state, state_nx;

  logic [IW-1:0]     ptr, ptr_nx;
  logic [IW-1:0]     idx_r, idx_nx;
  logic [NREQ-1:0]   mask, mask_nx;
  logic              we_r, we_nx;
  logic [AWIDTH-1:0] addr_r, addr_nx;
  logic [DWIDTH-1:0] wdata_r, wdata_nx;
  logic [NREQ-1:0]   rvalid_r, rvalid_nx;
  logic [DWIDTH-1:0] rdata_r, rdata_nx;

  // Round-robin pick results
  logic [NREQ-1:0]   cand;
  logic              found;
  logic [IW-1:0]     sel;
  logic              sel_we;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;

  logic [NREQ-1:0]   idx_oh;

  assign cand   = bus.req & ~mask;
  assign idx_oh = {{(NREQ-1){1'b0}}, 1'b1} << idx_r;

  //---------------------------------------------------------------------------
  // Round-robin search: first candidate at ptr, ptr+1, ... (mod NREQ).
  //---------------------------------------------------------------------------
  always_comb begin : rr_pick
    int unsigned j;
    j         = 0;
    found     = 1'b0;
    sel       = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!found && cand[j]) begin
        found     = 1'b1;
        sel       = IW'(j);
        sel_we    = bus.we[j];
        sel_addr  = bus.addr[j*AWIDTH +: AWIDTH];
        sel_wdata = bus.wdata[j*DWIDTH +: DWIDTH];
      end
    end
  end

  //---------------------------------------------------------------------------
  // State register
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      idx_r    <= '0;
      mask     <= '0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      rvalid_r <= '0;
      rdata_r  <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      idx_r    <= idx_nx;
      mask     <= mask_nx;
      we_r     <= we_nx;
      addr_r   <= addr_nx;
      wdata_r  <= wdata_nx;
      rvalid_r <= rvalid_nx;
      rdata_r  <= rdata_nx;
    end
  end

  //---------------------------------------------------------------------------
  // Next-state logic. mask defaults to zero so it only lives for the single
  // IDLE cycle that follows a completed transaction.
  //---------------------------------------------------------------------------
  always_comb begin : fsm_next
    state_nx  = state;
    ptr_nx    = ptr;
    idx_nx    = idx_r;
    we_nx     = we_r;
    addr_nx   = addr_r;
    wdata_nx  = wdata_r;
    mask_nx   = '0;
    rvalid_nx = '0;
    rdata_nx  = rdata_r;

    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          idx_nx   = sel;
          we_nx    = sel_we;
          addr_nx  = sel_addr;
          wdata_nx = sel_wdata;
        end
      end

      GRANT: begin
        ptr_nx = (idx_r == IW'(NREQ - 1)) ? '0 : idx_r + 1'b1;
        if (we_r) begin
          state_nx = IDLE;
          mask_nx  = idx_oh;
        end else begin
          state_nx = RWAIT;
        end
      end

      RWAIT: begin
        state_nx  = IDLE;
        mask_nx   = idx_oh;
        rvalid_nx = idx_oh;
        rdata_nx  = bus.mem_rdata;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  //---------------------------------------------------------------------------
  // Outputs. Memory-side signals are decoded from the registered state so
  // they are zero outside GRANT and drop immediately on reset.
  //---------------------------------------------------------------------------
  always_comb begin : outputs
    bus.gnt       = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state == GRANT) begin
      bus.gnt       = idx_oh;
      bus.mem_read  = ~we_r;
      bus.mem_write = we_r;
      bus.mem_addr  = addr_r;
      bus.mem_wdata = we_r ? wdata_r : '0;
    end
    bus.busy   = (state != IDLE);
    bus.rvalid = rvalid_r;
    bus.rdata  = rdata_r;
  end

endmodule
